sd_cmd_engine: RTL and testbench

Parametrised SD-bus command-line engine for the SD host controller: generates `sd_clk` from the system clock with a programmable divider and serialises 48-bit commands with CRC7 onto CMD. It then captures none, 48-bit or 136-bit responses with start-bit timeout and CRC7 checking. It sits between the controller's MMIO register file (which drives the command fields) and the CMD/CLK pads; the data lines are handled by a separate block.

---
 rtl/sd_pkg.sv | 44 ++++
 rtl/sd_crc7.sv | 37 +++
 rtl/sd_cmd_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Purpose  : Shared types and constants for the SD command-line engine:
//            FSM state encoding, response-type encodings, frame lengths,
//            the CRC7 generator polynomial and a single-bit CRC7 step.
// Revision : 1.0 - initial release
// ============================================================================
package sd_pkg;

  // Engine sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } sd_state_e;

  // Response type field as driven by the register file
  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,  // no response expected
    RESP_R48       = 2'd1,  // 48-bit, CRC7 checked
    RESP_R136      = 2'd2,  // 136-bit (R2)
    RESP_R48_NOCRC = 2'd3   // 48-bit, CRC field ignored (R3)
  } sd_resp_e;

  localparam int CMD_BITS = 48;
  localparam int R_SHORT  = 48;
  localparam int R_LONG   = 136;

  // x^7 + x^3 + 1, the x^7 term being implicit in the shift
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial CRC7 update, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb        = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc7
// Purpose  : Serial CRC7 accumulator (x^7+x^3+1, init 0), one bit per
//            enabled cycle, MSB-first.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clr_i      - clear accumulator to 0 (wins over en_i)
//            en_i       - accumulate din_i this cycle
//            din_i      - serial data bit
//            crc_o      - current CRC7 remainder
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= 7'h00;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, din_i);
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_engine
// Purpose  : SD-bus CMD line engine. Generates sd_clk from clk with a
//            programmable divider, serialises 48-bit commands with CRC7 and
//            captures none / 48-bit / 136-bit responses with start-bit
//            timeout and CRC7 checking.
// Ports    : clk, rst                 - system clock, sync active-high reset
//            div_i                    - sd_clk half period = div_i+1 clk cycles
//            cmd_start_i              - one-cycle request, taken when idle
//            cmd_index_i, cmd_arg_i   - command index and argument
//            resp_type_i              - 0 none, 1 R48+CRC, 2 R136, 3 R48 no CRC
//            busy_o, done_o           - command in progress / completion pulse
//            resp_o                   - captured response (right-aligned)
//            err_timeout_o, err_crc_o - response errors, valid with done_o
//            sd_clk_o                 - SD clock
//            sd_cmd_out_o, sd_cmd_oe_o, sd_cmd_in_i - CMD pad signals
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int RESP_TIMEOUT = 64,  // must be >= 1
  parameter int NCC          = 8    // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cmd_start_i,
  input  logic [5:0]       cmd_index_i,
  input  logic [31:0]      cmd_arg_i,
  input  logic [1:0]       resp_type_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [127:0]     resp_o,
  output logic             err_timeout_o,
  output logic             err_crc_o,
  output logic             sd_clk_o,
  output logic             sd_cmd_out_o,
  output logic             sd_cmd_oe_o,
  input  logic             sd_cmd_in_i
);

  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int GAP_W = $clog2(NCC + 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  sd_state_e        state_q;
  logic             busy_q;
  logic             done_q;
  logic [127:0]     resp_q;
  logic             err_timeout_q;
  logic             err_crc_q;
  logic             cmd_out_q;
  logic             cmd_oe_q;
  logic [DIV_W-1:0] div_q;        // divider value latched at accept
  sd_resp_e         resp_type_q;
  logic [39:0]      tx_sh_q;      // start, dir, index, arg - shifted MSB-first
  logic [7:0]       bit_cnt_q;    // TX bits sent or RX bits received
  logic [TO_W-1:0]  to_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [126:0]     rx_sh_q;      // response shift register (oldest bits drop off)

  logic [DIV_W-1:0] div_cnt_q;
  logic             sd_clk_q;

  // --------------------------------------------------------------------------
  // Clock divider and edge strobes
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_sel;
  logic             div_tick;
  logic             fall_stb;
  logic             rise_stb;

  // Only IDLE follows the live divider; a command runs at its latched rate.
  assign div_sel  = (state_q == ST_IDLE) ? div_i : div_q;
  assign div_tick = (div_cnt_q == '0);
  assign fall_stb = div_tick &  sd_clk_q;
  assign rise_stb = div_tick & ~sd_clk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sd_clk_q  <= 1'b0;
    end else if (div_tick) begin
      div_cnt_q <= div_sel;
      sd_clk_q  <= ~sd_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Accept and CRC generators
  // --------------------------------------------------------------------------
  logic       accept;
  logic       tx_crc_en;
  logic       rx_crc_en;
  logic [6:0] tx_crc;
  logic [6:0] rx_crc;

  assign accept = (state_q == ST_IDLE) && cmd_start_i && !busy_q;

  // TX CRC covers the first 40 frame bits as they leave the shift register.
  assign tx_crc_en = (state_q == ST_SEND) && fall_stb && (bit_cnt_q < 8'd40);

  // RX CRC covers received bits 1..40: the start bit seen in WAIT, then
  // RECV bits while fewer than 40 have been counted.
  assign rx_crc_en = rise_stb &&
                     (((state_q == ST_WAIT) && !sd_cmd_in_i) ||
                      ((state_q == ST_RECV) && (bit_cnt_q < 8'd40)));

  sd_crc7 u_crc_tx (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (tx_crc_en),
    .din_i (tx_sh_q[39]),
    .crc_o (tx_crc)
  );

  sd_crc7 u_crc_rx (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (rx_crc_en),
    .din_i (sd_cmd_in_i),
    .crc_o (rx_crc)
  );

  // --------------------------------------------------------------------------
  // TX bit selection: payload, then CRC7 MSB-first, then end bit.
  // Bits 40..46 have low three count bits 0..6, giving the CRC index directly.
  // --------------------------------------------------------------------------
  logic       tx_bit;
  logic [2:0] crc_idx;

  assign crc_idx = 3'd6 - bit_cnt_q[2:0];

  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt_q < 8'd40) begin
      tx_bit = tx_sh_q[39];
    end else if (bit_cnt_q < 8'd47) begin
      tx_bit = tx_crc[crc_idx];
    end
  end

  // --------------------------------------------------------------------------
  // RX helpers
  // --------------------------------------------------------------------------
  logic [127:0] rx_next;
  logic [7:0]   rx_last;

  assign rx_next = {rx_sh_q, sd_cmd_in_i};
  assign rx_last = (resp_type_q == RESP_R136) ? 8'(R_LONG - 1) : 8'(R_SHORT - 1);

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      resp_q        <= '0;
      err_timeout_q <= 1'b0;
      err_crc_q     <= 1'b0;
      cmd_out_q     <= 1'b1;
      cmd_oe_q      <= 1'b0;
      div_q         <= '0;
      resp_type_q   <= RESP_NONE;
      tx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      rx_sh_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            div_q         <= div_i;
            resp_type_q   <= sd_resp_e'(resp_type_i);
            tx_sh_q       <= {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
            bit_cnt_q     <= '0;
            rx_sh_q       <= '0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (fall_stb) begin
            if (bit_cnt_q == 8'(CMD_BITS)) begin
              // End bit has had its full period; release the line.
              cmd_oe_q  <= 1'b0;
              cmd_out_q <= 1'b1;
              bit_cnt_q <= '0;
              to_cnt_q  <= '0;
              gap_cnt_q <= '0;
              state_q   <= (resp_type_q == RESP_NONE) ? ST_GAP : ST_WAIT;
            end else begin
              cmd_oe_q  <= 1'b1;
              cmd_out_q <= tx_bit;
              tx_sh_q   <= {tx_sh_q[38:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end

        ST_WAIT: begin
          if (rise_stb) begin
            if (!sd_cmd_in_i) begin
              rx_sh_q   <= rx_next[126:0];
              bit_cnt_q <= 8'd1;
              state_q   <= ST_RECV;
            end else if (to_cnt_q == TO_W'(RESP_TIMEOUT - 1)) begin
              err_timeout_q <= 1'b1;
              gap_cnt_q     <= '0;
              state_q       <= ST_GAP;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (rise_stb) begin
            rx_sh_q   <= rx_next[126:0];
            bit_cnt_q <= bit_cnt_q + 8'd1;
            if (bit_cnt_q == rx_last) begin
              // rx_next holds the whole frame (48-bit) or its last 128 bits.
              resp_q <= rx_next;
              if ((resp_type_q == RESP_R48) && (rx_next[7:1] != rx_crc)) begin
                err_crc_q <= 1'b1;
              end
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (fall_stb) begin
            if (gap_cnt_q == GAP_W'(NCC - 1)) begin
              state_q <= ST_DONE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign resp_o        = resp_q;
  assign err_timeout_o = err_timeout_q;
  assign err_crc_o     = err_crc_q;
  assign sd_clk_o      = sd_clk_q;
  assign sd_cmd_out_o  = cmd_out_q;
  assign sd_cmd_oe_o   = cmd_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_engine
// Purpose  : Self-checking bench for sd_cmd_engine: captures the CMD frame,
//            plays a card that answers on the CMD line, and compares frame,
//            response, errors and latency with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_engine;

  localparam int NCC   = 8;
  localparam int LIMIT = 20000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   div;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic         err_timeout;
  logic         err_crc;
  logic         sd_clk;
  logic         sd_cmd_out;
  logic         sd_cmd_oe;
  logic         sd_cmd_in;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sd_cmd_engine #(.DIV_W(8), .RESP_TIMEOUT(64), .NCC(NCC)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .div_i         (div),
    .cmd_start_i   (cmd_start),
    .cmd_index_i   (cmd_index),
    .cmd_arg_i     (cmd_arg),
    .resp_type_i   (resp_type),
    .busy_o        (busy),
    .done_o        (done),
    .resp_o        (resp),
    .err_timeout_o (err_timeout),
    .err_crc_o     (err_crc),
    .sd_clk_o      (sd_clk),
    .sd_cmd_out_o  (sd_cmd_out),
    .sd_cmd_oe_o   (sd_cmd_oe),
    .sd_cmd_in_i   (sd_cmd_in)
  );

  // Card-side view of the command: bits are taken mid-bit on sd_clk rising.
  logic [47:0] cap_bits = '0;
  int          cap_n    = 0;
  always @(posedge sd_clk) begin
    #1;
    if (sd_cmd_oe) begin
      cap_bits = {cap_bits[46:0], sd_cmd_out};
      cap_n++;
    end
  end

  int done_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  logic [127:0] exp_resp;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] model_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic dir, input logic [5:0] idx,
                                              input logic [31:0] arg);
    logic [39:0] body;
    body = {1'b0, dir, idx, arg};
    return {body, model_crc7(body), 1'b1};
  endfunction

  // Wait for the next sd_clk 1->0 transition, polled on clk falling edges.
  task automatic wait_sd_fall(inout int w);
    logic prev;
    bit   fell;
    fell = 1'b0;
    prev = sd_clk;
    while (!fell && w < LIMIT) begin
      @(negedge clk);
      w++;
      fell = prev && !sd_clk;
      prev = sd_clk;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input bit reply_en, input logic [135:0] reply,
                         input int dly, input logic [7:0] dv, input logic [7:0] dv_busy,
                         input bit poke);
    int  n0, d0, cyc, rlen, p;
    bit  exp_to, exp_crc, in_range;
    logic [47:0] frm;
    rlen = (rt == 2'd2) ? 136 : 48;
    @(negedge clk);
    div       = dv;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = rt;
    cmd_start = 1'b1;
    n0 = cap_n;
    d0 = done_cnt;
    @(negedge clk);
    cmd_start = 1'b0;
    div       = dv_busy;
    check_eq({tag, ":busy_after_accept"}, 128'(busy), 128'(1));
    cyc = 0;
    fork
      begin
        int w;
        w = 0;
        if (reply_en && rt != 2'd0) begin
          while (!sd_cmd_oe && w < LIMIT) begin @(negedge clk); w++; end
          while (sd_cmd_oe && w < LIMIT) begin @(negedge clk); w++; end
          repeat (dly) wait_sd_fall(w);
          for (int i = rlen - 1; i >= 0; i--) begin
            wait_sd_fall(w);
            sd_cmd_in = reply[i];
          end
          wait_sd_fall(w);
          sd_cmd_in = 1'b1;
        end
      end
      begin
        while (!done && cyc < LIMIT) begin
          @(negedge clk);
          cyc++;
          if (poke && cyc == 60) begin
            cmd_start = 1'b1;
            cmd_index = ~idx;
            cmd_arg   = ~arg;
          end else begin
            cmd_start = 1'b0;
          end
        end
        cmd_start = 1'b0;
      end
    join
    // Values below are taken in the done cycle.
    exp_to  = (rt != 2'd0) && !reply_en;
    exp_crc = (rt == 2'd1) && reply_en && (reply[7:1] != model_crc7(reply[47:8]));
    if (rt != 2'd0 && reply_en)
      exp_resp = (rlen == 48) ? {80'b0, reply[47:0]} : reply[127:0];
    frm = model_frame(1'b1, idx, arg);
    check_eq({tag, ":done"}, 128'(done), 128'(1));
    check_eq({tag, ":busy_at_done"}, 128'(busy), 128'(0));
    check_eq({tag, ":err_timeout"}, 128'(err_timeout), 128'(exp_to));
    check_eq({tag, ":err_crc"}, 128'(err_crc), 128'(exp_crc));
    check_eq({tag, ":resp"}, resp, exp_resp);
    check_eq({tag, ":frame_len"}, 128'(cap_n - n0), 128'(48));
    check_eq({tag, ":frame"}, 128'(cap_bits), 128'(frm));
    if (rt == 2'd0) begin
      p = 2 * (int'(dv) + 1);
      in_range = (cyc >= (47 + NCC) * p) && (cyc <= (49 + NCC) * p + 8);
      check_eq({tag, ":latency"}, 128'(in_range), 128'(1));
    end
    @(negedge clk);
    check_eq({tag, ":done_pulses"}, 128'(done_cnt - d0), 128'(1));
    check_eq({tag, ":resp_stable"}, resp, exp_resp);
  endtask

  initial begin
    logic [135:0] rep;
    logic [159:0] rnd;
    logic [5:0]   ridx;
    logic [31:0]  rarg;
    logic [1:0]   rrt;
    logic [7:0]   rdv;
    int           n0, w;

    rst       = 1'b1;
    div       = 8'd1;
    cmd_start = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_type = '0;
    sd_cmd_in = 1'b1;
    exp_resp  = '0;
    repeat (4) @(negedge clk);
    check_eq("reset:sd_clk", 128'(sd_clk), 128'(0));
    check_eq("reset:cmd_out", 128'(sd_cmd_out), 128'(1));
    check_eq("reset:cmd_oe", 128'(sd_cmd_oe), 128'(0));
    check_eq("reset:busy", 128'(busy), 128'(0));
    check_eq("reset:done", 128'(done), 128'(0));
    check_eq("reset:resp", resp, 128'(0));
    check_eq("reset:errs", 128'({err_timeout, err_crc}), 128'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // CMD0, no response
    run_cmd("cmd0", 6'd0, 32'h0, 2'd0, 1'b0, '0, 0, 8'd1, 8'd1, 1'b0);
    check_eq("cmd0:frame_const", 128'(cap_bits), 128'(48'h400000000095));
    check_eq("cmd0:oe_released", 128'(sd_cmd_oe), 128'(0));

    // CMD8 with R7
    run_cmd("cmd8", 6'd8, 32'h000001AA, 2'd1, 1'b1, 136'(48'h08000001AA13), 5,
            8'd1, 8'd1, 1'b0);
    check_eq("cmd8:frame_const", 128'(cap_bits), 128'(48'h48000001AA87));
    check_eq("cmd8:resp_const", resp, 128'(48'h08000001AA13));
    check_eq("cmd8:err_crc_const", 128'(err_crc), 128'(0));

    // Corrupted reply CRC
    run_cmd("crcerr", 6'd8, 32'h000001AA, 2'd1, 1'b1, 136'(48'h08000001AA15), 5,
            8'd1, 8'd1, 1'b0);
    check_eq("crcerr:err_crc_const", 128'(err_crc), 128'(1));

    // No reply at all
    run_cmd("timeout", 6'd17, 32'h12345678, 2'd1, 1'b0, '0, 0, 8'd0, 8'd0, 1'b0);
    check_eq("timeout:err_const", 128'(err_timeout), 128'(1));
    check_eq("timeout:resp_kept", resp, 128'(48'h08000001AA15));

    // Long R2 reply
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rep = {8'h3F, 32'hDEADBEEF, rnd[94:0], 1'b1};
    run_cmd("long", 6'd2, 32'h0, 2'd2, 1'b1, rep, 3, 8'd1, 8'd1, 1'b0);
    check_eq("long:err_crc", 128'(err_crc), 128'(0));

    // Second request while busy must be dropped
    run_cmd("busyign", 6'h11, 32'hCAFE0001, 2'd0, 1'b0, '0, 0, 8'd1, 8'd1, 1'b1);
    n0 = cap_n;
    repeat (300) @(negedge clk);
    check_eq("busyign:no_second_frame", 128'(cap_n - n0), 128'(0));
    check_eq("busyign:idle_after", 128'(busy), 128'(0));

    // Reset in the middle of a command frame
    @(negedge clk);
    div = 8'd1; cmd_index = 6'h2A; cmd_arg = $urandom; resp_type = 2'd1; cmd_start = 1'b1;
    n0 = cap_n;
    @(negedge clk);
    cmd_start = 1'b0;
    w = 0;
    while ((cap_n - n0) < 20 && w < LIMIT) begin @(negedge clk); w++; end
    check_eq("rst:reached_bit20", 128'(cap_n - n0), 128'(20));
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst:cmd_oe", 128'(sd_cmd_oe), 128'(0));
    check_eq("rst:cmd_out", 128'(sd_cmd_out), 128'(1));
    check_eq("rst:busy", 128'(busy), 128'(0));
    check_eq("rst:sd_clk", 128'(sd_clk), 128'(0));
    check_eq("rst:resp", resp, 128'(0));
    rst = 1'b0;
    exp_resp = '0;
    n0 = cap_n;
    repeat (200) @(negedge clk);
    check_eq("rst:frame_abandoned", 128'(cap_n - n0), 128'(0));

    // Randomised commands against the model
    for (int k = 0; k < 8; k++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      rrt  = 2'($urandom_range(0, 3));
      rdv  = 8'($urandom_range(0, 3));
      if (rrt == 2'd2) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rep = rnd[135:0];
        rep[135:128] = 8'h3F;
        rep[0] = 1'b1;
      end else begin
        rep = 136'(model_frame(1'b0, ridx, rarg));
        if (rrt == 2'd3) rep[7:1] = 7'h7F;
        if ($urandom_range(0, 1) == 1) rep[7:1] = rep[7:1] ^ 7'($urandom_range(1, 127));
      end
      run_cmd($sformatf("rand%0d", k), ridx, rarg, rrt, 1'b1, rep,
              $urandom_range(2, 8), rdv, 8'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
